// File: rtl/bank_port_responder.sv
// Bank-side responder: accepts scheduler grants whose consumer id matches a local
// rotating pivot, services reads/writes on a bank RAM, and flags schedule violations.
module bank_port_responder #(
    parameter int NCONSUMERS = 8,
    parameter int NBANKS     = 4,
    parameter int NPORTS     = 2,
    parameter int BANK_ID    = 0,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 2,
    localparam int CW        = (NCONSUMERS > 1) ? $clog2(NCONSUMERS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NPORTS-1:0]        req_valid,
    input  logic [NPORTS*CW-1:0]     req_consumer,
    input  logic [NPORTS-1:0]        req_we,
    input  logic [NPORTS*ADDR_W-1:0] req_addr,
    input  logic [NPORTS*DATA_W-1:0] req_wdata,
    output logic [NPORTS-1:0]        resp_valid,
    output logic [NPORTS*CW-1:0]     resp_consumer,
    output logic [NPORTS*DATA_W-1:0] resp_rdata,
    output logic                     err,
    output logic [NPORTS-1:0]        err_port
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    logic [CW-1:0]     pivot_q    [NPORTS];
    logic              vld_q      [NPORTS][RD_LATENCY];
    logic [CW-1:0]     cons_q     [NPORTS][RD_LATENCY];
    logic [DATA_W-1:0] data_q     [NPORTS][RD_LATENCY];
    logic [NPORTS-1:0] err_port_q;

    logic [NPORTS-1:0] rd_acc;
    logic [NPORTS-1:0] wr_acc;
    logic [NPORTS-1:0] bad;

    // NOTE: every signal driven from always_comb gets a default first so no latch is inferred.
    always_comb begin
        rd_acc = '0;
        wr_acc = '0;
        bad    = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (req_valid[p]) begin
                if (req_consumer[p*CW +: CW] == pivot_q[p]) begin
                    rd_acc[p] = !req_we[p];
                    wr_acc[p] = req_we[p];
                end else begin
                    bad[p] = 1'b1;
                end
            end
        end
    end

    // Ascending port order makes the highest port's write the last one scheduled, so it wins.
    // NOTE: the RAM array has no reset; its contents deliberately survive reset and a reset
    // branch would prevent block-RAM mapping.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NPORTS; p++) begin
            if (wr_acc[p]) begin
                mem_q[req_addr[p*ADDR_W +: ADDR_W]] <= req_wdata[p*DATA_W +: DATA_W];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every register samples
    // pre-edge values; this is also what makes a same-edge read return the old RAM word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_port_q <= '0;
            for (int p = 0; p < NPORTS; p++) begin
                pivot_q[p] <= CW'((BANK_ID + p * NBANKS) % NCONSUMERS);
                for (int s = 0; s < RD_LATENCY; s++) begin
                    vld_q[p][s]  <= 1'b0;
                    cons_q[p][s] <= '0;
                    data_q[p][s] <= '0;
                end
            end
        end else begin
            err_port_q <= err_port_q | bad;
            for (int p = 0; p < NPORTS; p++) begin
                pivot_q[p] <= (pivot_q[p] == CW'(NCONSUMERS - 1)) ? '0 : pivot_q[p] + CW'(1);
                vld_q[p][0] <= rd_acc[p];
                if (rd_acc[p]) begin
                    cons_q[p][0] <= req_consumer[p*CW +: CW];
                    data_q[p][0] <= mem_q[req_addr[p*ADDR_W +: ADDR_W]];
                end
                for (int s = 1; s < RD_LATENCY; s++) begin
                    vld_q[p][s]  <= vld_q[p][s-1];
                    cons_q[p][s] <= cons_q[p][s-1];
                    data_q[p][s] <= data_q[p][s-1];
                end
            end
        end
    end

    always_comb begin
        resp_valid    = '0;
        resp_consumer = '0;
        resp_rdata    = '0;
        for (int p = 0; p < NPORTS; p++) begin
            resp_valid[p]                 = vld_q[p][RD_LATENCY-1];
            resp_consumer[p*CW +: CW]     = cons_q[p][RD_LATENCY-1];
            resp_rdata[p*DATA_W +: DATA_W] = data_q[p][RD_LATENCY-1];
        end
    end

    assign err_port = err_port_q;
    assign err      = |err_port_q;

endmodule
